// File: rtl/audio_pkg.sv
// audio_pkg: shared types and helpers for the audio echo datapath.
//   sample_t     - signed per-channel sample
//   stereo_t     - packed {l, r} stereo pair (l in the upper half)
//   SAT_MAX/MIN  - saturation limits of sample_t
//   echo_state_t - echo stage FSM states
//   echo_mix()   - dry + (delayed >>> shift), saturated to sample_t
package audio_pkg;

   localparam int SAMPLE_W = 32;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   typedef struct packed {
      sample_t l;
      sample_t r;
   } stereo_t;

   localparam sample_t SAT_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
   localparam sample_t SAT_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_OUT  = 2'd2
   } echo_state_t;

   // One extra bit of headroom makes overflow visible as a mismatch of the
   // top two sum bits; the top bit then tells which rail to clamp to.
   function automatic sample_t echo_mix(input sample_t dry,
                                        input sample_t dly,
                                        input logic [2:0] shift);
      sample_t                   att_v;
      logic signed [SAMPLE_W:0]  sum_v;
      sample_t                   res_v;
      att_v = dly >>> shift;
      sum_v = {dry[SAMPLE_W-1], dry} + {att_v[SAMPLE_W-1], att_v};
      if (sum_v[SAMPLE_W] != sum_v[SAMPLE_W-1]) begin
         res_v = sum_v[SAMPLE_W] ? SAT_MIN : SAT_MAX;
      end else begin
         res_v = sum_v[SAMPLE_W-1:0];
      end
      return res_v;
   endfunction

endpackage

// File: rtl/echo_ram.sv
// echo_ram: simple dual-port delay-line memory, 2**ADDR_W x DATA_W.
//   clk      - clock
//   wr_en    - write strobe; wr_data stored at wr_addr on the rising edge
//   rd_en    - read strobe; rd_data updated from rd_addr on the rising edge
//   rd_data  - registered read data, one-cycle latency, holds between reads
// No reset on the array or read register so the memory maps onto block RAM.
// A same-address read and write returns the old contents.
module echo_ram #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_r [0:(2**ADDR_W)-1];

   // Synchronous write port and registered read port.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem_r[rd_addr];
      end
   end

endmodule

// File: rtl/audio_echo_stage.sv
// audio_echo_stage: streaming stereo echo between the codec read and write
// handshakes. Each accepted sample is written into a circular delay line and
// the sample delay_len positions older is read back, attenuated by
// atten_shift and added to the dry sample with saturation.
//   CLOCK_50             - system clock
//   reset                - synchronous active-high reset
//   in_valid / in_ready  - input handshake (in_L, in_R, delay_len, atten_shift)
//   out_valid / out_ready- output handshake (out_L, out_R)
// One sample in flight at a time: IDLE (accept) -> READ -> OUT (hold).
module audio_echo_stage
   import audio_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  sample_t           in_L,
   input  sample_t           in_R,
   input  logic [ADDR_W-1:0] delay_len,
   input  logic [2:0]        atten_shift,
   output logic              out_valid,
   input  logic              out_ready,
   output sample_t           out_L,
   output sample_t           out_R
);

   localparam logic [ADDR_W-1:0] FILL_MAX = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam sample_t           ZERO_S   = {SAMPLE_W{1'b0}};

   echo_state_t           state_r;
   echo_state_t           state_s;
   logic                  accept_s;
   logic                  echo_en_s;
   logic [ADDR_W-1:0]     rd_addr_s;
   logic [2*SAMPLE_W-1:0] rd_data_s;
   stereo_t               rd_word_s;
   sample_t               dly_l_s;
   sample_t               dly_r_s;

   logic                  in_ready_r;
   logic                  out_valid_r;
   sample_t               out_l_r;
   sample_t               out_r_r;
   logic [ADDR_W-1:0]     wr_ptr_r;
   logic [ADDR_W-1:0]     fill_cnt_r;
   stereo_t               dry_r;
   logic [2:0]            atten_r;
   logic                  echo_en_r;

   assign accept_s  = (state_r == S_IDLE) && in_valid;
   // Modular subtraction wraps naturally in ADDR_W bits.
   assign rd_addr_s = wr_ptr_r - delay_len;
   // fill_cnt_r counts samples already written, so unwritten RAM is never echoed.
   assign echo_en_s = (delay_len != {ADDR_W{1'b0}}) && (delay_len <= fill_cnt_r);
   assign rd_word_s = rd_data_s;

   echo_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (2*SAMPLE_W)
   ) u_ram (
      .clk     (CLOCK_50),
      .wr_en   (accept_s),
      .wr_addr (wr_ptr_r),
      .wr_data ({in_L, in_R}),
      .rd_en   (accept_s),
      .rd_addr (rd_addr_s),
      .rd_data (rd_data_s)
   );

   // FSM state register.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (in_valid) begin
               state_s = S_READ;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_READ: begin
            state_s = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               state_s = S_IDLE;
            end else begin
               state_s = S_OUT;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // Delayed operand: zero when echo is disabled (also masks the delay_len=0 collision).
   always_comb begin
      dly_l_s = ZERO_S;
      dly_r_s = ZERO_S;
      if (echo_en_r) begin
         dly_l_s = rd_word_s.l;
         dly_r_s = rd_word_s.r;
      end else begin
         dly_l_s = ZERO_S;
         dly_r_s = ZERO_S;
      end
   end

   // Handshake flags, pointers, captured sample and registered result.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         out_l_r     <= ZERO_S;
         out_r_r     <= ZERO_S;
         wr_ptr_r    <= {ADDR_W{1'b0}};
         fill_cnt_r  <= {ADDR_W{1'b0}};
         dry_r       <= {2*SAMPLE_W{1'b0}};
         atten_r     <= 3'd0;
         echo_en_r   <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (in_valid) begin
                  dry_r      <= {in_L, in_R};
                  atten_r    <= atten_shift;
                  echo_en_r  <= echo_en_s;
                  wr_ptr_r   <= wr_ptr_r + ONE;
                  in_ready_r <= 1'b0;
                  if (fill_cnt_r != FILL_MAX) begin
                     fill_cnt_r <= fill_cnt_r + ONE;
                  end
               end
            end
            S_READ: begin
               out_l_r     <= echo_mix(dry_r.l, dly_l_s, atten_r);
               out_r_r     <= echo_mix(dry_r.r, dly_r_s, atten_r);
               out_valid_r <= 1'b1;
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_L     = out_l_r;
   assign out_R     = out_r_r;

endmodule
